spectro_frame_engine: RTL
=========================

// Module: spectro_frame_engine
// PURPOSE
//  Parametrised, single-clock successor of the spectrogram channel counter/readout path.
//  Counts rising edges on N_CH asynchronous channel inputs over a frame.
//  A frame closes on a programmed tick period or when any channel count saturates.
//  On close, the counts are snapshotted into a shadow bank and the live counters restart
//  immediately, so there is no dead time. The snapshot then streams out MSB-first on a
//  bit-serial valid/ready link.
// PARAMETERS
//  N_CH         15    number of counted channels (1..31)
//  CNT_W        12    width of every count word and of the timestamp word
//  FRAME_TICKS  1000  tick strobes per frame (1..2^CNT_W-1)
//  DROP_W       8     width of the dropped-frame counter
// PORTS
//  clk         in   1            system clock
//  reset       in   1            synchronous, active-high reset
//  ch_in       in   N_CH         asynchronous pulse inputs, bit i = channel i+1
//  tick        in   1            1-cycle time-base strobe, synchronous to clk
//  ser_data    out  1            serial bit, MSB-first
//  ser_valid   out  1            ser_data is valid
//  ser_ready   in   1            sink accepts a bit when ser_valid & ser_ready
//  ser_sof     out  1            high with the first bit of word 0
//  ser_eow     out  1            high with the last bit of each word
//  frame_cause out  2            cause of the frame being sent: {sat_close, period_close}
//  busy        out  1            shadow bank is occupied (frame not yet fully sent)
//  drop_cnt    out  DROP_W       frames lost because the shadow bank was busy; saturates
// BEHAVIOUR
//  Reset: all outputs 0, live/shadow counters 0, tick count 0, FSM in IDLE, synchronizers cleared.
//    Reset mid-stream abandons the frame; ser_valid is 0 from the next cycle.
//  Input path: per channel, a 2-FF synchronizer followed by a rising-edge register.
//    A clean input rise increments the live count 3 clk cycles later. Pulses must be >=2 clk high and low.
//  Live counts: CNT_W bits wide. A count that reaches 2^CNT_W-1 holds and does not wrap.
//  tick_cnt: increments on each tick and holds the number of ticks in the current frame.
//  Close condition: close = (tick & tick_cnt==FRAME_TICKS-1) | any live count == max.
//    It is evaluated from registered state, plus the current edge or tick.
//  On the close edge:
//    - if busy=0, the shadow loads word0 = tick_cnt (including the current tick) and
//      word i = count i (including the current edge), and frame_cause is latched;
//    - live counts and tick_cnt clear in all cases;
//    - an edge arriving in the close cycle is counted in the frame being closed, not the new one.
//  Simultaneous period and saturation close: one frame is produced with frame_cause=2'b11.
//  Close while busy=1: the frame is discarded and drop_cnt increments, holding at all-ones.
//    The stream in flight is unaffected.
//  FSM states:
//    IDLE --close & !busy--> SHIFT   (busy=1)
//    SHIFT: bit advances only on ser_valid & ser_ready; ser_valid stays high, data stable while stalled
//    SHIFT --last bit of word N_CH accepted--> IDLE   (busy=0)
//  ser_valid rises in the cycle after the close edge.
//  Word order is 0..N_CH. Each word is CNT_W bits, MSB first.
//    A frame is (N_CH+1)*CNT_W bits: 192 with the defaults.
//  If a close coincides with the last-bit handshake, that close is a drop. busy clears on the following edge.
//  ser_sof and ser_eow are valid only while ser_valid=1 and are 0 otherwise.
// TESTING
//  1. 5 rises on ch1, 3 on ch15, FRAME_TICKS ticks, ser_ready=1
//     -> words: TS=1000, ch1=5, ch15=3, others 0; frame_cause=01; 192 valid bits.
//  2. CNT_W=4: 15 rises on ch2 before period end
//     -> close in the cycle count hits 15; word2=15, frame_cause=10; ch2 restarts from 0.
//  3. Saturating edge and final tick in the same cycle -> single frame, frame_cause=11, drop_cnt=0.
//  4. ser_ready low for 50 cycles mid-word while a second close occurs
//     -> ser_data held stable, drop_cnt=1, the first frame completes intact.
//  5. Assert reset during bit 40 of a frame -> ser_valid=0 next cycle, busy=0, drop_cnt=0, counts 0.
//  6. Rise on ch3 lands exactly in the close cycle -> counted in the old frame; the new frame's ch3=0.

Source files
------------

// File: rtl/spectro_frame_engine.sv
// spectro_frame_engine
// Counts rising edges on N_CH asynchronous channel inputs over a frame. A frame closes
// after FRAME_TICKS tick strobes or as soon as any channel count saturates. On close the
// counts (plus the tick count as word 0) are snapshotted into a shadow shift register and
// the live counters restart in the same edge, so counting never pauses. The snapshot is
// streamed MSB-first, word 0 first, over a bit-serial valid/ready link.

module spectro_frame_engine #(
   parameter int N_CH        = 15,
   parameter int CNT_W       = 12,
   parameter int FRAME_TICKS = 1000,
   parameter int DROP_W      = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_CH-1:0]   ch_in,
   input  logic              tick,
   output logic              ser_data,
   output logic              ser_valid,
   input  logic              ser_ready,
   output logic              ser_sof,
   output logic              ser_eow,
   output logic [1:0]        frame_cause,
   output logic              busy,
   output logic [DROP_W-1:0] drop_cnt
);

   // Frame geometry: word 0 is the tick count, words 1..N_CH are the channel counts.
   localparam int N_WORDS    = N_CH + 1;
   localparam int FRAME_W    = N_WORDS * CNT_W;
   localparam int WORD_IDX_W = $clog2(N_WORDS);
   localparam int BIT_IDX_W  = (CNT_W > 1) ? $clog2(CNT_W) : 1;

   localparam logic [CNT_W-1:0]      CNT_MAX   = '1;
   localparam logic [CNT_W-1:0]      TICK_LAST = CNT_W'(FRAME_TICKS - 1);
   localparam logic [DROP_W-1:0]     DROP_MAX  = '1;
   localparam logic [WORD_IDX_W-1:0] LAST_WORD = WORD_IDX_W'(N_CH);
   localparam logic [BIT_IDX_W-1:0]  LAST_BIT  = BIT_IDX_W'(CNT_W - 1);

   // Streaming state machine: IDLE means the shadow bank is free.
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   logic [0:0]            state;
   logic [N_CH-1:0]       sync1;
   logic [N_CH-1:0]       sync2;
   logic [N_CH-1:0]       sync3;
   logic [N_CH-1:0]       rise;
   logic [CNT_W-1:0]      live_cnt [N_CH];
   logic [CNT_W-1:0]      live_nxt [N_CH];
   logic [CNT_W-1:0]      tick_cnt;
   logic [CNT_W-1:0]      tick_nxt;
   logic                  sat_close;
   logic                  period_close;
   logic                  close;
   logic [FRAME_W-1:0]    snap_vec;
   logic [FRAME_W-1:0]    shreg;
   logic [WORD_IDX_W-1:0] word_idx;
   logic [BIT_IDX_W-1:0]  bit_idx;

   // Two-flop synchronizer plus one history flop per channel for edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         sync3 <= '0;
      end else begin
         sync1 <= ch_in;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign rise = sync2 & ~sync3;

   // Next live counts including this cycle's edges; a count that reaches max triggers a close.
   always_comb begin
      sat_close = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         live_nxt[i] = live_cnt[i];
         if (rise[i] && (live_cnt[i] != CNT_MAX)) begin
            live_nxt[i] = live_cnt[i] + 1'b1;
         end
         if (live_nxt[i] == CNT_MAX) begin
            sat_close = 1'b1;
         end
      end
   end

   // Tick count including the current strobe; the period closes on the FRAME_TICKS-th tick.
   always_comb begin
      tick_nxt = tick_cnt;
      if (tick && (tick_cnt != CNT_MAX)) begin
         tick_nxt = tick_cnt + 1'b1;
      end
      period_close = tick && (tick_cnt == TICK_LAST);
   end

   assign close = sat_close | period_close;

   // Snapshot image laid out so that shifting left emits word 0 MSB first, then word 1, etc.
   always_comb begin
      snap_vec = '0;
      snap_vec[FRAME_W-1 -: CNT_W] = tick_nxt;
      for (int i = 0; i < N_CH; i++) begin
         snap_vec[(N_CH-1-i)*CNT_W +: CNT_W] = live_nxt[i];
      end
   end

   // Live counters restart on every close, whether or not the frame was captured.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_CH; i++) begin
            live_cnt[i] <= '0;
         end
         tick_cnt <= '0;
      end else if (close) begin
         for (int i = 0; i < N_CH; i++) begin
            live_cnt[i] <= '0;
         end
         tick_cnt <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            live_cnt[i] <= live_nxt[i];
         end
         tick_cnt <= tick_nxt;
      end
   end

   // Capture a closed frame when the bank is free, then shift it out one accepted bit at a time.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         shreg       <= '0;
         word_idx    <= '0;
         bit_idx     <= '0;
         frame_cause <= 2'b00;
      end else begin
         case (state)
            ST_IDLE: begin
               if (close) begin
                  state       <= ST_SHIFT;
                  shreg       <= snap_vec;
                  frame_cause <= {sat_close, period_close};
                  word_idx    <= '0;
                  bit_idx     <= '0;
               end
            end
            ST_SHIFT: begin
               if (ser_ready) begin
                  shreg <= shreg << 1;
                  if (bit_idx == LAST_BIT) begin
                     bit_idx <= '0;
                     if (word_idx == LAST_WORD) begin
                        state    <= ST_IDLE;
                        word_idx <= '0;
                     end else begin
                        word_idx <= word_idx + 1'b1;
                     end
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Frames that close while the bank is still streaming are lost; count them, saturating.
   always_ff @(posedge clk) begin
      if (reset) begin
         drop_cnt <= '0;
      end else if (close && (state == ST_SHIFT) && (drop_cnt != DROP_MAX)) begin
         drop_cnt <= drop_cnt + 1'b1;
      end
   end

   assign ser_valid = (state == ST_SHIFT);
   assign busy      = (state == ST_SHIFT);
   assign ser_data  = ser_valid & shreg[FRAME_W-1];
   assign ser_sof   = ser_valid && (word_idx == '0) && (bit_idx == '0);
   assign ser_eow   = ser_valid && (bit_idx == LAST_BIT);

endmodule
